uart_wb_bridge: RTL and testbench

- Wishbone B4 classic slave sitting directly upstream of the UART peripheral. It replaces the raw peripheral strobe interface on the bus.
- Buffers CPU transmit bytes in a TX FIFO and drains them one at a time into the peripheral's transmit path.
- Polls the peripheral's receive-ready flag and moves received bytes into an RX FIFO for the CPU to read.
- The CPU never needs to busy-wait on the TX-active or RX-ready peripheral flags.

---
 rtl/uart_wb_pkg.sv | 34 +++
 rtl/uart_byte_fifo.sv | 53 +++++
 rtl/uart_wb_bridge.sv | 152 +++++++++++++++
 tb/tb_uart_wb_bridge.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_wb_pkg.sv
// Shared constants for the UART Wishbone bridge: register map, status/ctrl
// bit positions, peripheral register addresses and the peripheral FSM states.
package uart_wb_pkg;

    localparam logic [1:0] REG_DATA   = 2'b00;
    localparam logic [1:0] REG_STATUS = 2'b01;
    localparam logic [1:0] REG_CTRL   = 2'b10;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_READY = 5;
    localparam int ST_TX_BUSY  = 6;
    localparam int ST_TX_CNT   = 8;
    localparam int ST_RX_CNT   = 16;

    localparam int CTRL_CLR_OVF  = 0;
    localparam int CTRL_FLUSH_TX = 1;
    localparam int CTRL_FLUSH_RX = 2;

    localparam logic [1:0] P_DATA = 2'b00;
    localparam logic [1:0] P_STAT = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RX_POP,
        RX_GAP,
        TX_LOAD,
        TX_ARM
    } bridge_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// 8-bit synchronous FIFO with push/pop/flush; pointers carry one extra wrap bit
// so full and empty are told apart by the pointer difference.
module uart_byte_fifo
    import uart_wb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  logic [7:0]  i_data,
    input  logic        i_pop,
    input  logic        i_flush,
    output logic [7:0]  o_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_count
);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == (AW + 1)'(DEPTH));
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // A flush discards any same-cycle push or pop; a pop frees room for a push.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_wb_bridge.sv
// Wishbone classic slave fronting the UART peripheral: TX/RX byte FIFOs plus a
// small FSM that moves bytes to and from the peripheral one access at a time.
module uart_wb_bridge
    import uart_wb_pkg::*;
#(
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 8,
    parameter int ARM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [1:0]  p_addr_o,
    output logic [31:0] p_wdata_o,
    output logic        p_we_o,
    output logic        p_sel_o,
    input  logic [31:0] p_rdata_i
);

    localparam int TXW = $clog2(TX_DEPTH) + 1;
    localparam int RXW = $clog2(RX_DEPTH) + 1;
    localparam int TW  = $clog2(ARM_TIMEOUT + 1);

    bridge_state_t r_state, w_next;
    logic          r_ack;
    logic [31:0]   r_dat;
    logic          r_tx_ovf;
    logic [1:0]    r_stat_q;
    logic [TW-1:0] r_tmo;

    logic          w_req, w_wr, w_rd, w_ctrl;
    logic [1:0]    w_reg;
    logic          w_flush_tx, w_flush_rx, w_clr_ovf, w_ovf_set;
    logic          w_cpu_push, w_cpu_pop, w_fsm_pop, w_fsm_push;
    logic [1:0]    w_stat_live;
    logic          w_rx_ready, w_tx_active, w_tx_busy;
    logic [7:0]    w_tx_head, w_rx_head;
    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [TXW-1:0] w_tx_count;
    logic [RXW-1:0] w_rx_count;
    logic [31:0]   w_status, w_rdata;
    logic          w_unused;

    assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_reg  = wb_adr_i[3:2];
    assign w_wr   = w_req & wb_we_i;
    assign w_rd   = w_req & ~wb_we_i;
    assign w_ctrl = w_wr & (w_reg == REG_CTRL);

    assign w_flush_tx = w_ctrl & wb_dat_i[CTRL_FLUSH_TX];
    assign w_flush_rx = w_ctrl & wb_dat_i[CTRL_FLUSH_RX];
    assign w_clr_ovf  = w_ctrl & wb_dat_i[CTRL_CLR_OVF];
    assign w_cpu_push = w_wr & (w_reg == REG_DATA) & wb_sel_i[0];
    assign w_cpu_pop  = w_rd & (w_reg == REG_DATA) & ~w_rx_empty;
    assign w_fsm_pop  = (r_state == TX_LOAD);
    assign w_fsm_push = (r_state == RX_POP);
    // A write into a full FIFO survives only if the FSM drains a byte that cycle.
    assign w_ovf_set  = w_cpu_push & w_tx_full & ~w_fsm_pop;

    assign w_unused = ^{p_rdata_i[31:8], wb_dat_i[31:8], wb_adr_i[1:0], wb_sel_i[3:1]};

    uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk(clk), .i_rst_n(rst_n), .i_push(w_cpu_push), .i_data(wb_dat_i[7:0]),
        .i_pop(w_fsm_pop), .i_flush(w_flush_tx), .o_data(w_tx_head),
        .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
    );

    uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk(clk), .i_rst_n(rst_n), .i_push(w_fsm_push), .i_data(p_rdata_i[7:0]),
        .i_pop(w_cpu_pop), .i_flush(w_flush_rx), .o_data(w_rx_head),
        .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
    );

    // Peripheral status is only on p_rdata_i while the status address is driven;
    // the last sampled copy stands in during data-address cycles.
    assign w_stat_live = p_sel_o ? r_stat_q : p_rdata_i[1:0];
    assign w_rx_ready  = w_stat_live[1];
    assign w_tx_active = w_stat_live[0];
    assign w_tx_busy   = ~w_tx_empty | w_tx_active | (r_state != IDLE);

    assign p_sel_o   = (r_state == RX_POP) || (r_state == TX_LOAD);
    assign p_we_o    = (r_state == TX_LOAD);
    assign p_addr_o  = p_sel_o ? P_DATA : P_STAT;
    assign p_wdata_o = p_we_o ? {24'h0, w_tx_head} : 32'h0;

    always_comb begin
        w_status = '0;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_RX_EMPTY] = w_rx_empty;
        w_status[ST_RX_FULL]  = w_rx_full;
        w_status[ST_TX_OVF]   = r_tx_ovf;
        w_status[ST_RX_READY] = w_rx_ready;
        w_status[ST_TX_BUSY]  = w_tx_busy;
        w_status[ST_TX_CNT +: 8] = 8'(w_tx_count);
        w_status[ST_RX_CNT +: 8] = 8'(w_rx_count);
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_DATA:   if (!w_rx_empty) w_rdata = {23'h0, 1'b1, w_rx_head};
            REG_STATUS: w_rdata = w_status;
            default:    w_rdata = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_rx_ready && !w_rx_full)        w_next = RX_POP;
                else if (!w_tx_empty && !w_tx_active) w_next = TX_LOAD;
            end
            RX_POP:  w_next = RX_GAP;
            RX_GAP:  w_next = IDLE;
            TX_LOAD: w_next = TX_ARM;
            TX_ARM:  if (w_tx_active || r_tmo == TW'(ARM_TIMEOUT)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tmo    <= '0;
            r_stat_q <= '0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_tx_ovf <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_tmo    <= (r_state == TX_ARM) ? r_tmo + 1'b1 : '0;
            if (!p_sel_o) r_stat_q <= p_rdata_i[1:0];
            r_ack    <= w_req;
            r_dat    <= w_rd ? w_rdata : '0;
            if (w_ovf_set)      r_tx_ovf <= 1'b1;
            else if (w_clr_ovf) r_tx_ovf <= 1'b0;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed-plus-random bench for uart_wb_bridge with a small UART peripheral
// model; TX/RX byte order is tracked with expected queues.
module tb_uart_wb_bridge;

    localparam int DEPTH = 8;
    localparam logic [1:0] R_DATA = 2'b00, R_STAT = 2'b01, R_CTRL = 2'b10, R_NONE = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_adr = '0;
    logic [31:0] wb_wdat = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [1:0]  p_addr_o;
    logic [31:0] p_wdata_o;
    logic        p_we_o, p_sel_o;
    logic [31:0] p_rdata_i;

    always #5 clk = ~clk;

    // Peripheral model state
    logic       force_tx = 1'b0;
    logic       auto_en = 1'b1;
    logic [7:0] rx_byte = '0;
    int         rx_posted = 0;
    int         rx_taken = 0;
    int         tx_t = 0;
    int         cyc_cnt = 0;
    int         n_loads = 0;
    int         n_rx_pops = 0;
    int         n_strobes = 0;
    int         bad_strobe = 0;
    logic [7:0] load_log [64];
    int         load_cyc [64];
    int         rx_pop_cyc [64];
    logic       tx_active, rx_ready;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_rx_q[$];

    assign tx_active = force_tx | (auto_en & (tx_t >= 2));
    assign rx_ready  = (rx_posted != rx_taken);

    always_comb begin
        case (p_addr_o)
            2'b00:   p_rdata_i = {24'h0, rx_byte};
            2'b01:   p_rdata_i = {30'h0, rx_ready, tx_active};
            default: p_rdata_i = 32'h0;
        endcase
    end

    // Transmitter goes active 2 cycles after a load and stays active 40 cycles.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst_n && p_sel_o) begin
            n_strobes <= n_strobes + 1;
            if (p_addr_o != 2'b00 || (p_we_o && (tx_active || p_wdata_o[31:8] != 0)) ||
                (!p_we_o && !rx_ready))
                bad_strobe <= bad_strobe + 1;
            if (p_we_o) begin
                load_log[n_loads] <= p_wdata_o[7:0];
                load_cyc[n_loads] <= cyc_cnt;
                n_loads <= n_loads + 1;
            end else begin
                rx_pop_cyc[n_rx_pops] <= cyc_cnt;
                n_rx_pops <= n_rx_pops + 1;
                rx_taken <= rx_taken + 1;
            end
        end
        if (rst_n && p_sel_o && p_we_o) tx_t <= 1;
        else if (tx_t != 0)             tx_t <= (tx_t == 41) ? 0 : tx_t + 1;
    end

    uart_wb_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_dat_i(wb_wdat), .wb_sel_i(wb_sel), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .p_addr_o(p_addr_o), .p_wdata_o(p_wdata_o), .p_we_o(p_we_o), .p_sel_o(p_sel_o),
        .p_rdata_i(p_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(int txc, int rxc, bit ovf, bit rxr, bit busy);
        int v;
        v = (txc == DEPTH ? 1 : 0) + (txc == 0 ? 2 : 0) + (rxc == 0 ? 4 : 0) +
            (rxc == DEPTH ? 8 : 0) + (ovf ? 16 : 0) + (rxr ? 32 : 0) + (busy ? 64 : 0) +
            txc * 256 + rxc * 65536;
        return 32'(v);
    endfunction

    task automatic wb_xfer(input logic we, input logic [1:0] r, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd);
        int lat;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = {r, 2'b00}; wb_wdat = d; wb_sel = sel;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (wb_ack_o !== 1'b1 && lat < 8);
        rd = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check("ack_latency", 32'(lat), 32'd1);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'h0, wb_ack_o}, 32'h0);
        check("dat_idle_zero", wb_dat_o, 32'h0);
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, r, d, 4'h1, dummy);
    endtask

    task automatic wb_read(input logic [1:0] r, output logic [31:0] rd);
        wb_xfer(1'b0, r, 32'h0, 4'hf, rd);
    endtask

    task automatic post_rx(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_posted++;
    endtask

    task automatic wait_loads(input int n, input int budget);
        for (int i = 0; i < budget && n_loads < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n, input int budget);
        for (int i = 0; i < budget && n_rx_pops < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int base, nrand, saved;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_psel", {31'h0, p_sel_o}, 32'h0);
        check("rst_pwe", {31'h0, p_we_o}, 32'h0);
        check("rst_paddr", {30'h0, p_addr_o}, 32'h1);
        check("rst_pwdata", p_wdata_o, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        wb_read(R_STAT, rd);
        check("status_after_reset", rd, exp_status(0, 0, 0, 0, 0));

        // Two bytes drain in order, second waits for the transmitter to finish
        wb_write(R_DATA, 32'h41);
        wb_write(R_DATA, 32'h42);
        wait_loads(2, 300);
        check("two_loads", 32'(n_loads), 32'd2);
        check("load0_data", {24'h0, load_log[0]}, 32'h41);
        check("load1_data", {24'h0, load_log[1]}, 32'h42);
        check("load_gap_after_fall", (load_cyc[1] - load_cyc[0] >= 42) ? 32'd1 : 32'd0, 32'd1);
        repeat (50) @(posedge clk);
        wb_read(R_STAT, rd);
        check("status_tx_drained", rd, exp_status(0, 0, 0, 0, 0));

        // Overflow, byte-select gating, clear and flush while the transmitter is held busy
        @(negedge clk) force_tx = 1'b1;
        wb_xfer(1'b1, R_DATA, 32'h99, 4'b1110, rd);
        wb_read(R_STAT, rd);
        check("sel0_low_no_push", rd, exp_status(0, 0, 0, 0, 1));
        for (int i = 0; i < 9; i++) wb_write(R_DATA, 32'h60 + 32'(i));
        wb_read(R_STAT, rd);
        check("status_overflow", rd, exp_status(8, 0, 1, 0, 1));
        wb_write(R_CTRL, 32'h1);
        wb_read(R_STAT, rd);
        check("status_ovf_cleared", rd, exp_status(8, 0, 0, 0, 1));
        wb_read(R_CTRL, rd);
        check("ctrl_reads_zero", rd, 32'h0);
        wb_write(R_NONE, 32'hffff_ffff);
        wb_read(R_NONE, rd);
        check("reg3_reads_zero", rd, 32'h0);
        wb_write(R_CTRL, 32'h2);
        wb_read(R_STAT, rd);
        check("status_tx_flushed", rd, exp_status(0, 0, 0, 0, 1));
        @(negedge clk) force_tx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_load_after_flush", 32'(n_loads), 32'd2);

        // Single receive byte
        post_rx(8'h5A);
        wait_pops(1, 50);
        check("rx_pop_count", 32'(n_rx_pops), 32'd1);
        repeat (3) @(posedge clk);
        wb_read(R_DATA, rd);
        check("rx_read_5a", rd, 32'h0000_015A);
        wb_read(R_DATA, rd);
        check("rx_read_empty", rd, 32'h0);

        // RX takes priority over a pending TX load
        @(negedge clk) force_tx = 1'b1;
        wb_write(R_DATA, 32'h77);
        @(negedge clk);
        rx_byte = 8'h33; rx_posted++; force_tx = 1'b0;
        wait_loads(3, 100);
        check("prio_loads", 32'(n_loads), 32'd3);
        check("prio_pops", 32'(n_rx_pops), 32'd2);
        check("prio_load_data", {24'h0, load_log[2]}, 32'h77);
        check("rx_before_tx", (rx_pop_cyc[1] < load_cyc[2]) ? 32'd1 : 32'd0, 32'd1);
        wb_read(R_DATA, rd);
        check("prio_rx_read", rd, 32'h0000_0133);
        repeat (50) @(posedge clk);

        // Fill RX with random bytes, leave a ninth pending, TX still drains
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_rx_q.push_back(b);
            post_rx(b);
            wait_pops(3 + i, 50);
        end
        b = 8'($urandom_range(0, 255));
        exp_rx_q.push_back(b);
        post_rx(b);
        repeat (10) @(posedge clk);
        #1;
        check("rx_full_no_pop", 32'(n_rx_pops), 32'd10);
        wb_write(R_DATA, 32'h88);
        wait_loads(4, 100);
        check("rx_full_tx_drains", {24'h0, load_log[3]}, 32'h88);
        check("rx_full_still_no_pop", 32'(n_rx_pops), 32'd10);
        repeat (50) @(posedge clk);
        wb_read(R_STAT, rd);
        check("status_rx_full", rd, exp_status(0, DEPTH, 0, 1, 0));
        for (int i = 0; i < DEPTH + 1; i++) begin
            wb_read(R_DATA, rd);
            check("rx_random_read", rd, {23'h0, 1'b1, exp_rx_q.pop_front()});
        end
        wb_read(R_DATA, rd);
        check("rx_drained_read", rd, 32'h0);
        check("rx_total_pops", 32'(n_rx_pops), 32'd11);

        // Reset while waiting in TX_ARM (transmitter never starts)
        @(negedge clk) auto_en = 1'b0;
        for (int i = 0; i < 4; i++) wb_write(R_DATA, 32'hA0 + 32'(i));
        check("arm_one_load", 32'(n_loads), 32'd5);
        wb_read(R_STAT, rd);
        check("arm_three_queued", rd, exp_status(3, 0, 0, 0, 1));
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst_psel", {31'h0, p_sel_o}, 32'h0);
        check("midrst_pwe", {31'h0, p_we_o}, 32'h0);
        check("midrst_paddr", {30'h0, p_addr_o}, 32'h1);
        check("midrst_pwdata", p_wdata_o, 32'h0);
        check("midrst_ack", {31'h0, wb_ack_o}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        saved = n_strobes;
        repeat (40) @(posedge clk);
        #1;
        check("no_strobe_after_reset", 32'(n_strobes), 32'(saved));
        wb_read(R_STAT, rd);
        check("status_after_midrst", rd, exp_status(0, 0, 0, 0, 0));

        // Random TX burst checked against the expected queue
        @(negedge clk) auto_en = 1'b1;
        base = n_loads;
        nrand = $urandom_range(3, 6);
        for (int i = 0; i < nrand; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            wb_write(R_DATA, {24'h0, b});
        end
        wait_loads(base + nrand, nrand * 60 + 100);
        check("random_load_count", 32'(n_loads), 32'(base + nrand));
        for (int i = 0; i < nrand; i++)
            check("random_load_data", {24'h0, load_log[base + i]}, {24'h0, exp_q.pop_front()});
        check("peripheral_protocol", 32'(bad_strobe), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
